// File: rtl/nand_latch_driver_pkg.sv
// Shared types and defaults for the NAND S-R latch driver.
// NAND_LATCH_DRIVER_QFB_SYNC_EN stretches the guard so synchronized Q_FB has settled before the check.
package nand_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int PULSE_W_DEF = 4;
  localparam int GUARD_W_DEF = 2;
  localparam int SYNC_STAGES = 2;

  // Number of cycles spent in GUARD for a given guard width.
  function automatic int guard_len(input int gw);
`ifdef NAND_LATCH_DRIVER_QFB_SYNC_EN
    return gw + SYNC_STAGES;
`else
    return gw;
`endif
  endfunction

endpackage

// File: rtl/nand_latch_driver_if.sv
// Command handshake and completion report of the latch driver.
// master issues commands and observes DONE/ERR; slave is the driver.
interface nand_latch_driver_if;
  logic CMD_VALID;
  logic CMD_SET;
  logic CMD_READY;
  logic DONE;
  logic ERR;

  modport master (output CMD_VALID, output CMD_SET, input CMD_READY, input DONE, input ERR);
  modport slave  (input CMD_VALID, input CMD_SET, output CMD_READY, output DONE, output ERR);
endinterface

// File: rtl/nand_latch_driver_qfb_sync.sv
// Multi-flop synchronizer for the latch Q feedback; STAGES cycles of latency, no backpressure.
// Used only when NAND_LATCH_DRIVER_QFB_SYNC_EN is defined.
module qfb_sync
  import nand_latch_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/nand_latch_driver.sv
// Drives one active-low Sn/Rn pulse per command, then a guard gap and a Q readback; DONE PULSE_W+guard+1 cycles after accept.
// CMD_READY only in IDLE (including the DONE cycle); optional Q_FB synchronizer via NAND_LATCH_DRIVER_QFB_SYNC_EN.
module nand_latch_driver
  import nand_latch_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  nand_latch_driver_if.slave  cmd,
  output logic                Sn,
  output logic                Rn,
  input  logic                Q_FB
);

  localparam int               GUARD_LEN = guard_len(GUARD_W);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             sn_q, sn_d;
  logic             rn_q, rn_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             q_s;

`ifdef NAND_LATCH_DRIVER_QFB_SYNC_EN
  qfb_sync #(.STAGES(SYNC_STAGES)) u_qfb_sync (
    .CLK  (CLK),
    .RSTn (RSTn),
    .d    (Q_FB),
    .q    (q_s)
  );
`else
  assign q_s = Q_FB;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.CMD_VALID && rdy_q) begin
          tgt_d   = cmd.CMD_SET;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GUARD_LD;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (q_s != tgt_q);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are computed from the next state so they register in step with it.
    sn_d  = !((state_d == PULSE) &&  tgt_d);
    rn_d  = !((state_d == PULSE) && !tgt_d);
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      sn_q    <= 1'b1;
      rn_q    <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sn_q    <= sn_d;
      rn_q    <= rn_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Sn            = sn_q;
  assign Rn            = rn_q;
  assign cmd.CMD_READY = rdy_q;
  assign cmd.DONE      = done_q;
  assign cmd.ERR       = err_q;

endmodule

// File: tb/tb_nand_latch_driver.sv
// Bench for nand_latch_driver: command table against a NAND latch model, DONE/ERR scoreboard, reset corner cases.
module tb_nand_latch_driver;
  import nand_latch_pkg::*;

  localparam int PW = 4;
  localparam int GW = 2;
`ifdef NAND_LATCH_DRIVER_QFB_SYNC_EN
  localparam int GE = GW + 2;
`else
  localparam int GE = GW;
`endif

  typedef struct {
    bit s;
    bit frc;
    bit exp_err;
    bit exp_q;
  } vec_t;

  typedef struct {
    int cyc;
    bit err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sn, rn, q_fb;
  logic q_lat = 1'b0;
  bit   force_q = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   inv_bad = 0;
  int   err_stray = 0;
  exp_t sb[$];

  nand_latch_driver_if bus ();

  nand_latch_driver #(
    .PULSE_W (PW),
    .GUARD_W (GW),
    .CNT_W   (8)
  ) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .cmd  (bus.slave),
    .Sn   (sn),
    .Rn   (rn),
    .Q_FB (q_fb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NAND S-R latch behaviour with 1 ns response; both inputs high holds state.
  always begin
    @(sn or rn);
    #1;
    if (!sn) q_lat = 1'b1;
    else if (!rn) q_lat = 1'b0;
  end

  assign q_fb = force_q ? 1'b0 : q_lat;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  initial forever begin
    @(negedge clk);
    if (!sn && !rn) inv_bad++;
    if (!bus.DONE && bus.ERR) err_stray++;
    if (bus.DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("err_flag", bus.ERR, e.err);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.CMD_READY && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.CMD_READY) check("ready_timeout", bus.CMD_READY, 1);
  endtask

  task automatic run_cmd(input bit s, input bit frc, input bit exp_err, input bit exp_q, input bit imm);
    bit ok_p = 1'b1;
    bit ok_g = 1'b1;
    int a;
    if (imm) check("no_bubble_ready", bus.CMD_READY, 1);
    wait_ready();
    force_q       = frc;
    bus.CMD_SET   = s;
    bus.CMD_VALID = 1'b1;
    @(negedge clk);
    a = cyc;
    sb.push_back('{a + PW + GE, exp_err});
    for (int c = 1; c <= PW + GE; c++) begin
      if (c <= PW) begin
        if (sn != !s || rn != s || bus.CMD_READY) ok_p = 1'b0;
      end else if (!sn || !rn || bus.CMD_READY) begin
        ok_g = 1'b0;
      end
      // Noise while busy must be ignored.
      bus.CMD_VALID = 1'($urandom_range(0, 1));
      bus.CMD_SET   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.CMD_VALID = 1'b0;
    check(s ? "set_pulse" : "clr_pulse", ok_p, 1);
    check("guard_gap", ok_g, 1);
    check("ready_at_done", bus.CMD_READY, 1);
    check("latch_q", q_lat, exp_q);
    force_q = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0};

    bus.CMD_VALID = 1'b0;
    bus.CMD_SET   = 1'b0;
    rst_n         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {sn, rn, bus.CMD_READY, bus.DONE}, 4'b1100);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.CMD_READY, 1);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vt[i].s, vt[i].frc, vt[i].exp_err, vt[i].exp_q, i > 0);
    end

    // Reset during the second cycle of a set pulse abandons the command.
    bus.CMD_SET   = 1'b1;
    bus.CMD_VALID = 1'b1;
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    check("abort_pulse_started", sn, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {sn, rn, bus.CMD_READY, bus.DONE}, 4'b1100);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", bus.CMD_READY, 1);
    check("latch_after_partial", q_lat, 1);
    run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (12) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("sn_rn_never_both_low", inv_bad, 0);
    check("err_only_with_done", err_stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
